// File: rtl/multdiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: FSM encoding,
// fixed latencies and the most-negative 32-bit value.
package multdiv_unit_pkg;

  localparam int WIDTH    = 32;
  localparam int MULT_LAT = 17;
  localparam int DIV_LAT  = 33;

  // Counter values at which the finalize step runs (LAT-1).
  localparam logic [5:0] MULT_LAST = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_LAT - 1);

  localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  // A 64-bit product overflows 32 bits when the upper word is not the sign
  // extension of bit 31.
  function automatic logic mult_overflow(input logic [63:0] prod);
    return prod[63:32] != {32{prod[31]}};
  endfunction

endpackage

// File: rtl/multdiv_unit_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
// chained through group generate/propagate terms.
module cla_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;
  logic [8:0]  gc;

  // Per-group lookahead carries followed by the bitwise sum.
  always_comb begin
    g     = a_i & b_i;
    p     = a_i ^ b_i;
    c     = '0;
    gc    = '0;
    gc[0] = cin_i;
    for (int k = 0; k < 8; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum_o  = p ^ c;
    cout_o = gc[8];
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (radix-4 Booth) / divide (non-restoring on
// magnitudes) with fixed latency and a one-cycle ready pulse.
module multdiv_unit
  import multdiv_unit_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic [64:0] acc_q;      // mult: {P, multiplier, guard}; div: {R[32:0], Q}
  logic [31:0] opnd_q;     // multiplicand, or divisor magnitude
  logic        qneg_q, div0_q, ovf_q;
  logic [31:0] result_q;
  logic        exc_q, rdy_q, busy_q;

  logic        start;
  logic        b_zero, b_two, b_neg;
  logic [31:0] step_a, step_b, step_sum;
  logic        step_cin, step_cout;
  logic [31:0] neg_a, neg_sum;
  logic        neg_cout_unused;
  logic        step_ext;
  logic [33:0] booth_sum;
  logic [64:0] mult_d, div_d;

  assign start = ctrl_MULT | ctrl_DIV;

  // Radix-4 Booth recoding of {y[i+1], y[i], y[i-1]}.
  always_comb begin
    b_zero = 1'b0;
    b_two  = 1'b0;
    b_neg  = 1'b0;
    unique case (acc_q[2:0])
      3'b000, 3'b111: b_zero = 1'b1;
      3'b001, 3'b010: ;
      3'b011:         b_two = 1'b1;
      3'b100:         begin b_two = 1'b1; b_neg = 1'b1; end
      default:        b_neg = 1'b1;
    endcase
  end

  // Step adder operand select: |B| at start, Booth add, or divider add/sub.
  // The 33rd sum bit is recovered from the operand signs and carry-out.
  always_comb begin
    step_a   = acc_q[64:33];
    step_b   = '0;
    step_cin = 1'b0;
    if (start) begin
      step_a   = ~data_operandB;
      step_cin = 1'b1;
    end else if (state_q == DIV) begin
      step_a   = acc_q[62:31];
      step_b   = acc_q[64] ? opnd_q : ~opnd_q;
      step_cin = ~acc_q[64];
    end else begin
      step_a   = b_two ? {acc_q[64], acc_q[64:34]} : acc_q[64:33];
      step_b   = b_zero ? 32'd0 : (b_neg ? ~opnd_q : opnd_q);
      step_cin = b_neg & ~b_zero;
    end
  end

  cla_32 u_step_add (
    .a_i   (step_a),
    .b_i   (step_b),
    .cin_i (step_cin),
    .sum_o (step_sum),
    .cout_o(step_cout)
  );

  // Negation adder: |A| at start, otherwise the quotient sign fix.
  assign neg_a = start ? ~data_operandA : ~acc_q[31:0];

  cla_32 u_neg_add (
    .a_i   (neg_a),
    .b_i   (32'd0),
    .cin_i (1'b1),
    .sum_o (neg_sum),
    .cout_o(neg_cout_unused)
  );

  // Next shift-register values for one Booth step and one divider step.
  always_comb begin
    if (state_q == DIV)
      step_ext = acc_q[63] ^ ~acc_q[64] ^ step_cout;
    else
      step_ext = step_a[31] ^ step_b[31] ^ step_cout;
    booth_sum = b_two ? {step_ext, step_sum, acc_q[33]} : {step_ext, step_ext, step_sum};
    mult_d    = {booth_sum, acc_q[32:3], acc_q[2]};
    div_d     = {step_ext, step_sum, acc_q[30:0], ~step_ext};
  end

  // Datapath registers: operand capture on start, one iteration per cycle.
  always_ff @(posedge clock) begin
    if (start) begin
      if (ctrl_MULT) begin
        opnd_q <= data_operandA;
        acc_q  <= {32'd0, data_operandB, 1'b0};
      end else begin
        opnd_q <= data_operandB[31] ? step_sum : data_operandB;
        acc_q  <= {33'd0, data_operandA[31] ? neg_sum : data_operandA};
        qneg_q <= data_operandA[31] ^ data_operandB[31];
        div0_q <= (data_operandB == 32'd0);
        ovf_q  <= (data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF);
      end
    end else if (state_q == MULT && cnt_q != MULT_LAST) begin
      acc_q <= mult_d;
    end else if (state_q == DIV && cnt_q != DIV_LAST) begin
      acc_q <= div_d;
    end
  end

  // Control FSM with registered result, exception, ready and busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else if (start) begin
      state_q <= ctrl_MULT ? MULT : DIV;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        MULT: begin
          if (cnt_q == MULT_LAST) begin
            result_q <= acc_q[32:1];
            exc_q    <= mult_overflow(acc_q[64:1]);
            rdy_q    <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DIV: begin
          if (cnt_q == DIV_LAST) begin
            if (div0_q) begin
              result_q <= '0;
              exc_q    <= 1'b1;
            end else begin
              result_q <= qneg_q ? neg_sum : acc_q[31:0];
              exc_q    <= ovf_q;
            end
            rdy_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          rdy_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: expected results are queued when an
// operation is started and popped when the ready pulse appears.
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];        // {exception, result}
  logic [32:0] last_exp;

  localparam int ML = 17;
  localparam int DL = 33;

  multdiv_unit dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [32:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return {p[63:32] != {32{p[31]}}, p[31:0]};
  endfunction

  function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q;
    if (b == 32'd0) return {1'b1, 32'd0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    return {1'b0, q};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge E0.
  // Returns at the negedge after E0.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input bit push);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    if (push) exp_q.push_back(m ? model_mult(a, b) : model_div(a, b));
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // From the negedge after E0: no RDY before E0+lat, busy throughout,
  // RDY with the queued result after E0+lat, then idle with held outputs.
  task automatic wait_done(input string tag, input int lat);
    int early = 0;
    int busy_low = 0;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clock);
      if (j < lat && data_resultRDY) early++;
      if (!busy) busy_low++;
    end
    check({tag, "_early_rdy"}, early, 0);
    check({tag, "_busy_run"}, busy_low, 0);
    check({tag, "_rdy"}, 32'(data_resultRDY), 1);
    check({tag, "_sb_size"}, 32'(exp_q.size()), 1);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check({tag, "_result"}, data_result, last_exp[31:0]);
      check({tag, "_exc"}, 32'(data_exception), 32'(last_exp[32]));
    end
    @(negedge clock);
    check({tag, "_rdy_drop"}, 32'(data_resultRDY), 0);
    check({tag, "_busy_drop"}, 32'(busy), 0);
    check({tag, "_hold"}, data_result, last_exp[31:0]);
  endtask

  initial begin
    int rdy_seen;
    logic [31:0] ra, rb;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    last_exp      = '0;
    repeat (3) @(negedge clock);
    check("rst_result", data_result, 0);
    check("rst_exc", 32'(data_exception), 0);
    check("rst_rdy", 32'(data_resultRDY), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    @(negedge clock);

    start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 1);           wait_done("mul_7x-3", ML);
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1);   wait_done("mul_ovf", ML);
    start_op(1, 0, 32'h8000_0000, 32'h8000_0000, 1);   wait_done("mul_minmin", ML);
    start_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);   wait_done("mul_m1m1", ML);
    start_op(1, 1, 32'd6, 32'd7, 1);                   wait_done("mul_both", ML);
    start_op(0, 1, 32'hFFFF_FF9C, 32'd7, 1);           wait_done("div_-100_7", DL);
    start_op(0, 1, 32'd5, 32'd0, 1);                   wait_done("div_by0", DL);
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1);   wait_done("div_ovf", DL);
    start_op(0, 1, 32'h8000_0000, 32'h8000_0000, 1);   wait_done("div_minmin", DL);
    start_op(0, 1, 32'd7, 32'hFFFF_FFFE, 1);           wait_done("div_7_-2", DL);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      start_op(1, 0, ra, rb, 1);                       wait_done("mul_rand", ML);
      ra = $urandom; rb = $urandom >> (i * 8);
      start_op(0, 1, ra, rb, 1);                       wait_done("div_rand", DL);
    end

    // Restart: MULT aborted by a DIV started at E0+5.
    start_op(1, 0, 32'd3, 32'd4, 0);
    repeat (4) @(negedge clock);
    start_op(0, 1, 32'd20, 32'd5, 1);                  wait_done("restart", DL);

    // Reset at E0+10 during a divide.
    start_op(0, 1, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_result", data_result, 0);
    check("midrst_exc", 32'(data_exception), 0);
    check("midrst_rdy", 32'(data_resultRDY), 0);
    check("midrst_busy", 32'(busy), 0);
    reset = 1'b0;
    rdy_seen = 0;
    repeat (30) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("midrst_no_rdy", rdy_seen, 0);
    start_op(1, 0, 32'd2, 32'd2, 1);                   wait_done("post_rst_mul", ML);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
